// File: rtl/demux_rr_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module      : demux_rr_dispatcher_if
// Description : Upstream beat, per-channel output and status bundle for the
//               round-robin / fixed-channel dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
interface demux_rr_dispatcher_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         mode;
    logic [2:0]   fix_sel;
    logic [7:0]   out_ready;
    logic [7:0]   out_valid;
    logic [W-1:0] out_data;
    logic [2:0]   sel;
    logic [15:0]  beat_cnt;

    // master: the environment around the dispatcher (source and sinks)
    modport master (
        output in_valid, in_data, mode, fix_sel, out_ready,
        input  in_ready, out_valid, out_data, sel, beat_cnt
    );

    modport slave (
        input  in_valid, in_data, mode, fix_sel, out_ready,
        output in_ready, out_valid, out_data, sel, beat_cnt
    );
endinterface
`default_nettype wire

// File: rtl/demux_rr_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : demux_rr_dispatcher
// Description : One-entry output register dispatching beats to one of eight
//               channels, round-robin or fixed, with a handshake counter.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_rr_dispatcher #(
    parameter int W = 8
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    demux_rr_dispatcher_if.slave   bus
);
    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]   state_q, state_d;
    logic [W-1:0] data_q;
    logic [2:0]   sel_q;
    logic         mode_q;
    logic [2:0]   ptr_q;
    logic [15:0]  cnt_q;

    logic         hs;
    logic         load;
    logic         in_ready_w;
    logic [2:0]   ptr_eff;
    logic [2:0]   rr_sel;
    logic [2:0]   scan_idx;
    logic         found;
    logic [2:0]   sel_new;

    assign hs   = (state_q == S_FULL) && bus.out_ready[sel_q];
    assign load = bus.in_valid && in_ready_w;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (load)        state_d = S_FULL;
            S_FULL:  if (hs && !load) state_d = S_EMPTY;
            default:                  state_d = S_EMPTY;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready_w    = rst_n && ((state_q == S_EMPTY) || hs);
        bus.in_ready  = in_ready_w;
        bus.out_valid = (state_q == S_FULL) ? (8'h01 << sel_q) : 8'h00;
        bus.out_data  = data_q;
        bus.sel       = sel_q;
        bus.beat_cnt  = cnt_q;
    end

    // A handshake retiring a round-robin beat advances the pointer in the same
    // cycle, so a back-to-back load must scan from the advanced position.
    always_comb begin
        ptr_eff  = (hs && !mode_q) ? (sel_q + 3'd1) : ptr_q;
        rr_sel   = ptr_eff;
        scan_idx = ptr_eff;
        found    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            scan_idx = ptr_eff + 3'(i);
            if (!found && bus.out_ready[scan_idx]) begin
                rr_sel = scan_idx;
                found  = 1'b1;
            end
        end
        sel_new = bus.mode ? bus.fix_sel : rr_sel;
    end

    // Datapath: beat, locked select, dispatch mode, pointer and counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
            sel_q  <= 3'd0;
            mode_q <= 1'b0;
            ptr_q  <= 3'd0;
            cnt_q  <= 16'd0;
        end else begin
            if (load) begin
                data_q <= bus.in_data;
                sel_q  <= sel_new;
                mode_q <= bus.mode;
            end
            if (hs) begin
                cnt_q <= cnt_q + 16'd1;
            end
            ptr_q <= ptr_eff;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_demux_rr_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_rr_dispatcher
// Description : Scoreboard bench for demux_rr_dispatcher with a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_rr_dispatcher;
    logic clk;
    logic rst_n;

    demux_rr_dispatcher_if #(.W(8)) ifc ();

    demux_rr_dispatcher #(.W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] sel;
        logic [7:0] data;
    } ent_t;

    ent_t       sb[$];
    logic [2:0] hs_log[$];

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model of the dispatcher, evaluated mid-cycle
    logic        m_full = 1'b0;
    logic [2:0]  m_sel  = 3'd0;
    logic        m_mode = 1'b0;
    logic [2:0]  m_ptr  = 3'd0;
    logic [15:0] m_cnt  = 16'd0;

    always @(negedge clk) begin
        logic hs;
        logic rdy;
        logic [2:0] ns;
        logic [2:0] k;
        ent_t e;
        if (!rst_n) begin
            chk("rst_in_ready", {31'd0, ifc.in_ready}, 32'd0);
            m_full = 1'b0;
            m_sel  = 3'd0;
            m_mode = 1'b0;
            m_ptr  = 3'd0;
            m_cnt  = 16'd0;
            sb.delete();
        end else begin
            hs  = m_full && ifc.out_ready[m_sel];
            rdy = !m_full || hs;
            chk("in_ready", {31'd0, ifc.in_ready}, {31'd0, rdy});
            chk("out_valid", {24'd0, ifc.out_valid}, m_full ? (32'd1 << m_sel) : 32'd0);
            chk("beat_cnt", {16'd0, ifc.beat_cnt}, {16'd0, m_cnt});
            if (m_full) begin
                chk("sel_held", {29'd0, ifc.sel}, {29'd0, m_sel});
                if (sb.size() > 0) chk("data_held", {24'd0, ifc.out_data}, {24'd0, sb[0].data});
            end
            if (hs) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", sb.size(), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("hs_data", {24'd0, ifc.out_data}, {24'd0, e.data});
                    chk("hs_sel", {29'd0, ifc.sel}, {29'd0, e.sel});
                end
                hs_log.push_back(ifc.sel);
                m_cnt = m_cnt + 16'd1;
                if (!m_mode) m_ptr = m_sel + 3'd1;
            end
            if (ifc.in_valid && rdy) begin
                if (ifc.mode) begin
                    ns = ifc.fix_sel;
                end else begin
                    ns = m_ptr;
                    for (int j = 7; j >= 0; j--) begin
                        k = m_ptr + 3'(j);
                        if (ifc.out_ready[k]) ns = k;
                    end
                end
                sb.push_back('{sel: ns, data: ifc.in_data});
                m_full = 1'b1;
                m_sel  = ns;
                m_mode = ifc.mode;
            end else if (hs) begin
                m_full = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] d);
        logic ok;
        ok = 1'b0;
        ifc.in_valid = 1'b1;
        ifc.in_data  = d;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (ifc.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        chk("send_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_log(input string tag, input logic [2:0] exp[$]);
        chk({tag, "_n"}, hs_log.size(), exp.size());
        if (hs_log.size() == exp.size()) begin
            foreach (exp[i]) chk(tag, {29'd0, hs_log[i]}, {29'd0, exp[i]});
        end
        hs_log.delete();
    endtask

    initial begin
        time t0;
        rst_n         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.in_data   = 8'h00;
        ifc.mode      = 1'b0;
        ifc.fix_sel   = 3'd0;
        ifc.out_ready = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {24'd0, ifc.out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, ifc.out_data}, 32'd0);
        chk("rst_sel", {29'd0, ifc.sel}, 32'd0);
        chk("rst_beat_cnt", {16'd0, ifc.beat_cnt}, 32'd0);
        chk("rst_in_ready_now", {31'd0, ifc.in_ready}, 32'd0);
        rst_n = 1'b1;

        // Back-to-back round robin over all ready channels
        t0 = $time;
        for (int i = 0; i < 9; i++) send(8'h10 + 8'(i));
        chk("rr_rate", 32'(($time - t0) / 10), 32'd9);
        idle(2);
        chk("rr_beat_cnt", {16'd0, ifc.beat_cnt}, 32'd9);
        chk_log("rr_sel", '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0});

        // Skip unready channels starting from ptr=2
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        send(8'h01);
        send(8'h02);
        idle(2);
        hs_log.delete();
        ifc.out_ready = 8'b1000_0001;
        send(8'hA5);
        chk("skip_sel", {29'd0, ifc.sel}, 32'd7);
        chk("skip_valid", {24'd0, ifc.out_valid}, 32'h80);
        send(8'hA6);
        idle(2);
        chk_log("skip_log", '{3'd7, 3'd0});

        // Stall on channel 4 with no re-routing
        ifc.out_ready = 8'hFF;
        ifc.mode      = 1'b1;
        ifc.fix_sel   = 3'd4;
        send(8'h3C);
        ifc.out_ready = 8'hEF;
        ifc.mode      = 1'b0;
        ifc.in_valid  = 1'b1;
        ifc.in_data   = 8'h99;
        idle(5);
        chk("stall_valid", {24'd0, ifc.out_valid}, 32'h10);
        chk("stall_data", {24'd0, ifc.out_data}, 32'h3C);
        chk("stall_in_ready", {31'd0, ifc.in_ready}, 32'd0);
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 8'hFF;
        idle(2);
        chk("stall_beat_cnt", {16'd0, ifc.beat_cnt}, 32'd5);
        chk_log("stall_log", '{3'd4});

        // Fixed mode, fix_sel change while FULL, ptr untouched (ptr=1 here)
        ifc.mode    = 1'b1;
        ifc.fix_sel = 3'd5;
        for (int i = 0; i < 3; i++) send(8'h50 + 8'(i));
        idle(2);
        ifc.out_ready = 8'h00;
        send(8'h77);
        ifc.fix_sel = 3'd2;
        idle(3);
        chk("fix_hold_sel", {29'd0, ifc.sel}, 32'd5);
        chk("fix_hold_valid", {24'd0, ifc.out_valid}, 32'h20);
        ifc.out_ready = 8'hFF;
        send(8'h78);
        chk("fix_new_sel", {29'd0, ifc.sel}, 32'd2);
        ifc.mode = 1'b0;
        send(8'h79);
        idle(2);
        chk_log("fix_log", '{3'd5, 3'd5, 3'd5, 3'd5, 3'd2, 3'd1});

        // Reset while FULL on channel 3
        ifc.out_ready = 8'h08;
        send(8'h33);
        ifc.out_ready = 8'h00;
        idle(2);
        chk("pre_rst_valid", {24'd0, ifc.out_valid}, 32'h08);
        hs_log.delete();
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        chk("mid_rst_valid", {24'd0, ifc.out_valid}, 32'd0);
        chk("mid_rst_cnt", {16'd0, ifc.beat_cnt}, 32'd0);
        ifc.out_ready = 8'hFF;
        send(8'h44);
        idle(2);
        chk_log("post_rst_log", '{3'd0});

        // Counter wrap
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        for (int i = 0; i < 65536; i++) send(8'(i));
        idle(2);
        chk("wrap_cnt", {16'd0, ifc.beat_cnt}, 32'd0);
        hs_log.delete();
        send(8'hE1);
        send(8'hE2);
        idle(2);
        chk("wrap_after_cnt", {16'd0, ifc.beat_cnt}, 32'd2);
        chk_log("wrap_log", '{3'd0, 3'd1});

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
